// File: rtl/apb_irq_aggregator.sv
// apb_irq_aggregator: APB-mapped interrupt aggregator with pending latches, masks, W1C and lowest-index-first active ID
module apb_irq_aggregator #(
  parameter int                   NUM_IRQ   = 8,
  parameter logic [NUM_IRQ-1:0]   EDGE_MASK = 8'h01
) (
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic               PSEL,
  input  logic               PENABLE,
  input  logic               PWRITE,
  input  logic [4:2]         PADDR,
  input  logic [31:0]        PWDATA,
  output logic [31:0]        PRDATA,
  input  logic [NUM_IRQ-1:0] IRQ_IN,
  output logic               IRQ_OUT
);
  logic [NUM_IRQ-1:0] pending_q, pending_d, enable_q, enable_d, irq_prev_q;
  logic [NUM_IRQ-1:0] hw_set, sw_set, w1c, act;
  logic [4:0]         act_id;
  logic [31:0]        rd;
  logic               wr, irq_out_q, unused_wdata;
  assign unused_wdata = ^PWDATA;
  assign wr     = PSEL & PENABLE & PWRITE;
  assign w1c    = (wr && PADDR == 3'd1) ? PWDATA[NUM_IRQ-1:0] : '0;
  assign sw_set = (wr && PADDR == 3'd4) ? PWDATA[NUM_IRQ-1:0] : '0;
  // edge sources only fire when the previous sample was low; level sources fire whenever high
  assign hw_set    = IRQ_IN & ~(EDGE_MASK & irq_prev_q);
  assign pending_d = (pending_q & ~w1c) | hw_set | sw_set;
  assign enable_d  = (wr && PADDR == 3'd2) ? PWDATA[NUM_IRQ-1:0] : enable_q;
  assign act       = pending_q & enable_q;
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      pending_q  <= '0;
      enable_q   <= '0;
      irq_prev_q <= '0;
      irq_out_q  <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      irq_prev_q <= IRQ_IN;
      irq_out_q  <= |act;
    end
  end
  always_comb begin
    act_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (act[i]) act_id = 5'(i);
  end
  always_comb begin
    rd = '0;
    case (PADDR)
      3'd0:    rd = 32'(IRQ_IN);
      3'd1:    rd = 32'(pending_q);
      3'd2:    rd = 32'(enable_q);
      3'd3:    rd = {|act, 26'b0, act_id};
      default: rd = '0;
    endcase
    PRDATA = (PSEL && !PWRITE && !PRESET) ? rd : '0;
  end
  assign IRQ_OUT = irq_out_q;
endmodule

// File: tb/tb_apb_irq_aggregator.sv
// tb_apb_irq_aggregator: directed scoreboard bench for apb_irq_aggregator
module tb_apb_irq_aggregator;
  logic        PCLK = 1'b0, PRESET = 1'b1, PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [4:2]  PADDR = '0;
  logic [31:0] PWDATA = '0, PRDATA;
  logic [7:0]  IRQ_IN = '0;
  logic        IRQ_OUT;
  int          n_assert = 0, n_fail = 0;
  logic [31:0] exp_q[$];

  apb_irq_aggregator dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .IRQ_IN(IRQ_IN), .IRQ_OUT(IRQ_OUT)
  );

  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(negedge PCLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    e = exp_q.pop_front();
    n_assert++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  task automatic peek(input logic [2:0] a, input logic [31:0] e, input string tag);
    exp_q.push_back(e);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
    #1 chk(tag, PRDATA);
    PSEL = 1'b0;
  endtask

  task automatic irq(input logic e, input string tag);
    exp_q.push_back({31'b0, e});
    #1 chk(tag, {31'b0, IRQ_OUT});
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    tick();
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
    tick();
    PENABLE = 1'b1;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // reset values, PRDATA forced to 0 while reset is held
    IRQ_IN = 8'h10;
    repeat (2) tick();
    peek(3'd0, 32'h0, "raw_in_reset");
    IRQ_OUT_in_reset: irq(1'b0, "irq_in_reset");
    IRQ_IN = 8'h00;
    tick();
    PRESET = 1'b0;
    for (int a = 0; a < 8; a++) peek(3'(a), 32'h0, $sformatf("reset_addr%0d", a));
    irq(1'b0, "reset_irq");

    // edge source 0: two-edge latency, W1C, no re-trigger while held
    wr(3'd2, 32'h01);
    peek(3'd2, 32'h01, "enable_rd");
    IRQ_IN = 8'h01;
    tick();
    IRQ_IN = 8'h00;
    peek(3'd1, 32'h01, "edge_pend");
    irq(1'b0, "edge_irq_edge1");
    tick();
    irq(1'b1, "edge_irq_edge2");
    peek(3'd3, 32'h8000_0000, "edge_active");
    wr(3'd1, 32'h01);
    peek(3'd1, 32'h00, "edge_w1c_pend");
    irq(1'b1, "edge_w1c_irq_same");
    tick();
    irq(1'b0, "edge_w1c_irq_next");
    IRQ_IN = 8'h01;
    repeat (2) tick();
    peek(3'd1, 32'h01, "held_pend");
    wr(3'd1, 32'h01);
    repeat (3) tick();
    peek(3'd1, 32'h00, "held_no_retrig");
    irq(1'b0, "held_irq");
    IRQ_IN = 8'h00;
    tick();

    // level source 1: set wins over W1C while input is high
    wr(3'd2, 32'h02);
    IRQ_IN = 8'h02;
    repeat (2) tick();
    peek(3'd1, 32'h02, "lvl_pend");
    irq(1'b1, "lvl_irq");
    wr(3'd1, 32'h02);
    peek(3'd1, 32'h02, "lvl_w1c_high");
    tick();
    irq(1'b1, "lvl_irq_stays");
    IRQ_IN = 8'h00;
    tick();
    wr(3'd1, 32'h02);
    peek(3'd1, 32'h00, "lvl_w1c_low");
    tick();
    irq(1'b0, "lvl_irq_low");

    // SOFTSET, mask and lowest-index priority
    wr(3'd4, 32'h0C);
    peek(3'd4, 32'h0, "softset_rd");
    wr(3'd2, 32'h08);
    peek(3'd3, 32'h8000_0003, "active_3");
    wr(3'd2, 32'h0C);
    peek(3'd3, 32'h8000_0002, "active_2");
    tick();
    irq(1'b1, "mask_irq_on");
    wr(3'd2, 32'h00);
    peek(3'd3, 32'h0, "active_none");
    irq(1'b1, "mask_irq_same");
    tick();
    irq(1'b0, "mask_irq_off");
    peek(3'd1, 32'h0C, "mask_pend_kept");

    // W1C of bit 0 on the same edge as a rising edge of IRQ_IN[0]
    tick();
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = 3'd1; PWDATA = 32'h01;
    tick();
    PENABLE = 1'b1; IRQ_IN = 8'h01;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    peek(3'd1, 32'h0D, "simul_set_wins");
    wr(3'd1, 32'h0D);
    peek(3'd1, 32'h00, "simul_clear");

    // asynchronous reset mid-operation with IRQ_IN[0] held high
    wr(3'd4, 32'hFF);
    wr(3'd2, 32'hFF);
    tick();
    irq(1'b1, "pre_reset_irq");
    #2 PRESET = 1'b1;
    irq(1'b0, "async_reset_irq");
    peek(3'd1, 32'h0, "pend_in_reset");
    tick();
    PRESET = 1'b0;
    peek(3'd1, 32'h00, "pend_after_rst");
    peek(3'd2, 32'h00, "en_after_rst");
    tick();
    peek(3'd1, 32'h01, "edge_after_rst");
    wr(3'd1, 32'h01);
    IRQ_IN = 8'h00;

    // writes to read-only and reserved addresses change nothing
    wr(3'd2, 32'h05);
    wr(3'd6, 32'hFFFF_FFFF);
    wr(3'd0, 32'hFFFF_FFFF);
    wr(3'd3, 32'hFFFF_FFFF);
    peek(3'd1, 32'h00, "unmapped_pend");
    peek(3'd2, 32'h05, "unmapped_en");
    peek(3'd6, 32'h00, "reserved6_rd");
    peek(3'd7, 32'h00, "reserved7_rd");
    IRQ_IN = 8'hA4;
    peek(3'd0, 32'hA4, "raw_rd");
    tick();
    IRQ_IN = 8'h00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_irq_aggregator.md
Name: apb_irq_aggregator

Overview:
- Downstream of the APB timer and sibling peripherals: collects their interrupt outputs (e.g. TIMINT) into one CPU interrupt line for the MiV core.
- Per-source pending latches, enable masks, W1C clear, software set, lowest-index-first active-ID readout.
- APB3-style slave without PREADY/PSLVERR, on the same APB segment and clock as the timer.

Parameters:
- NUM_IRQ, 8, number of interrupt sources (1..31).
- EDGE_MASK, 8'h01, per-source mode bit; 1 = rising-edge sensitive, 0 = level (active-high). Width NUM_IRQ.

Ports:
- PCLK  in  1  APB/system clock, all logic rising-edge.
- PRESET  in  1  asynchronous reset, active-high.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write.
- PADDR  in  3 [4:2]  word address.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- IRQ_IN  in  NUM_IRQ  source interrupts, active-high, synchronous to PCLK.
- IRQ_OUT  out  1  aggregated interrupt to CPU, active-high.

Behaviour:
- Reset (PRESET high, asynchronous): pending=0, enable=0, irq_prev=0, IRQ_OUT=0. PRDATA is combinational and reads 0 while reset is asserted.
- Write strobe: PSEL & PENABLE & PWRITE. Register updates take effect on that PCLK edge.
- PRDATA: combinational during any PSEL & !PWRITE cycle (setup and access). Reads 0 otherwise and for unmapped addresses. Unused upper bits read 0.
- Register map (PADDR[4:2]):
  - 0 RAW: RO, IRQ_IN sampled (current cycle).
  - 1 PENDING: RW1C. Writing 1 clears bit i, writing 0 has no effect.
  - 2 ENABLE: RW, plain register.
  - 3 ACTIVE: RO. Bit31 = valid (any pending&enable); bits[4:0] = lowest index i with pending[i]&enable[i], else 0.
  - 4 SOFTSET: WO, writing 1 sets pending[i]. Reads 0.
  - 5..7: reserved, read 0, writes ignored.
- Edge sources (EDGE_MASK[i]=1):
  - irq_prev[i] registers IRQ_IN[i] every cycle.
  - set_i = IRQ_IN[i] & ~irq_prev[i], so pending[i] is set on the edge where the rising edge is seen.
  - pending stays set until W1C.
  - A source held high does not re-trigger.
- Level sources (EDGE_MASK[i]=0):
  - set_i = IRQ_IN[i] every cycle.
  - W1C while input is still high: pending stays 1 (set wins).
  - Clears only once the input is low and W1C is written.
- Priority per bit, per edge: reset > set (hardware or SOFTSET) > W1C clear > hold.
- Pending is independent of ENABLE: a disabled source still latches. Enabling it later asserts IRQ_OUT.
- IRQ_OUT is registered: IRQ_OUT <= |(pending & enable).
  - Latency from the IRQ_IN rising edge sample to IRQ_OUT high: 2 PCLK edges (edge 1 sets pending, edge 2 sets IRQ_OUT).
  - Latency from a W1C of the last pending bit to IRQ_OUT low: 1 edge after the write edge.
- Writes to PADDR 0 and 3 are ignored. No error response.
- Reset mid-transfer: state clears immediately. An in-flight write is lost. After deassert, the next rising edge of an already-high edge source is detected (irq_prev=0 after reset).

Test Plan:
- Reset values: assert PRESET, read all 8 addresses after release -> all return 0x00000000. IRQ_OUT=0.
- Edge latency: ENABLE=0x01, pulse IRQ_IN[0] high for 1 cycle -> PENDING=0x01 next cycle, IRQ_OUT=1 two edges after the sample, ACTIVE=0x80000000. W1C PENDING=0x01 -> IRQ_OUT=0 one edge later. A held-high IRQ_IN[0] does not re-pend.
- Level source: ENABLE=0x02, IRQ_IN[1]=1 held.
  - W1C 0x02 -> PENDING still 0x02, IRQ_OUT stays 1.
  - Drop IRQ_IN[1], then W1C -> PENDING=0, IRQ_OUT=0.
- Priority and mask:
  - SOFTSET=0x0C, ENABLE=0x08 -> ACTIVE=0x80000003.
  - ENABLE=0x0C -> ACTIVE=0x80000002.
  - ENABLE=0 -> ACTIVE=0, IRQ_OUT=0 one edge later, PENDING=0x0C unchanged.
- Simultaneous set/clear: W1C PENDING bit0 on the same edge as a rising edge on IRQ_IN[0] -> PENDING[0]=1 afterwards.
- Reset mid-operation: pending=0xFF, IRQ_OUT=1, assert PRESET asynchronously between edges -> IRQ_OUT=0 immediately, PENDING=0 after release. Unmapped addr 6 write 0xFFFFFFFF -> no register changes.
